// File: rtl/lms_update_ctrl_pkg.sv
// Shared definitions for the LMS update controller and its latency counter:
// state encoding, default latencies and datapath dimensions used by the
// filter and weight RAM that sit beside this controller.
package lms_update_ctrl_pkg;

  localparam int DEF_FIR_LAT = 4;
  localparam int DEF_DIV_LAT = 3;
  localparam int NUM_TAPS    = 16;
  localparam int DATA_W      = 14;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_FILT = 3'd2,
    ST_ERR  = 3'd3,
    ST_DIVW = 3'd4,
    ST_UPD  = 3'd5,
    ST_OUT  = 3'd6
  } lms_state_e;

  // Latency counter width: enough bits for the larger latency plus one spare,
  // so the load value itself always fits.
  function automatic int lat_cnt_w(input int fir_lat, input int div_lat);
    int m;
    m = (fir_lat > div_lat) ? fir_lat : div_lat;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/lms_lat_cnt.sv
// Down-counter that measures a fixed wait. A start pulse loads the length;
// done_o is high during the last cycle of the wait. The counter stops at
// zero and never wraps.
module lms_lat_cnt #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [CNT_W-1:0] len_i,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q;
  logic             run_q;

  // Load on start, count down while running, stop after the last cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (start_i) begin
      cnt_q <= len_i - CNT_W'(1);
      run_q <= 1'b1;
    end else if (run_q) begin
      if (cnt_q == '0) begin
        run_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  assign done_o = run_q && (cnt_q == '0);

endmodule

// File: rtl/lms_update_ctrl.sv
// Per-sample sequencer for the 16-tap LMS adaptive filter. Takes one sample,
// pulses the delay-line shift, waits out the FIR, latches the error, then
// (when adapting) waits out the divider and pulses the weight update once.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready_o is only high in IDLE, so in_valid_i elsewhere is simply
// not taken. out_valid_o stays high until out_ready_i is seen at an edge;
// out_ready_i while out_valid_o is low has no effect.
module lms_update_ctrl
  import lms_update_ctrl_pkg::*;
#(
  parameter int FIR_LAT = DEF_FIR_LAT,
  parameter int DIV_LAT = DEF_DIV_LAT,
  parameter int ITER_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic              adapt_en_i,
  output logic              shift_en_o,
  output logic              err_latch_o,
  output logic              weight_cal_state_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              busy_o,
  output logic [ITER_W-1:0] iter_cnt_o,
  output lms_state_e        state_o
);

  localparam int CNT_W = lat_cnt_w(FIR_LAT, DIV_LAT);

  lms_state_e        state_q, state_d;
  logic              in_ready_q;
  logic              shift_en_q;
  logic              err_latch_q;
  logic              wcal_q;
  logic              out_valid_q;
  logic              busy_q;
  logic [ITER_W-1:0] iter_cnt_q;

  logic              lat_start;
  logic [CNT_W-1:0]  lat_len;
  logic              lat_done;

  // Counter is reloaded on entry to FILT (from LOAD) and DIVW (from ERR).
  always_comb begin
    lat_start = 1'b0;
    lat_len   = CNT_W'(DIV_LAT);
    if (state_q == ST_LOAD) begin
      lat_start = 1'b1;
      lat_len   = CNT_W'(FIR_LAT);
    end else if (state_q == ST_ERR && adapt_en_i) begin
      lat_start = 1'b1;
    end
  end

  lms_lat_cnt #(
    .CNT_W (CNT_W)
  ) u_lat_cnt (
    .clk     (clk),
    .rst     (rst),
    .start_i (lat_start),
    .len_i   (lat_len),
    .done_o  (lat_done)
  );

  // Next-state selection; adapt_en_i only matters in ERR.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid_i && in_ready_q) state_d = ST_LOAD;
      ST_LOAD: state_d = ST_FILT;
      ST_FILT: if (lat_done) state_d = ST_ERR;
      ST_ERR:  state_d = adapt_en_i ? ST_DIVW : ST_OUT;
      ST_DIVW: if (lat_done) state_d = ST_UPD;
      ST_UPD:  state_d = ST_OUT;
      ST_OUT:  if (out_ready_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register with Moore outputs decoded from the next state, so every
  // output is a flop; iteration count advances as UPD completes and saturates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b0;
      shift_en_q  <= 1'b0;
      err_latch_q <= 1'b0;
      wcal_q      <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      iter_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d == ST_IDLE);
      shift_en_q  <= (state_d == ST_LOAD);
      err_latch_q <= (state_d == ST_ERR);
      wcal_q      <= (state_d == ST_UPD);
      out_valid_q <= (state_d == ST_OUT);
      busy_q      <= (state_d != ST_IDLE);
      if (state_q == ST_UPD && iter_cnt_q != '1) begin
        iter_cnt_q <= iter_cnt_q + ITER_W'(1);
      end
    end
  end

  assign in_ready_o         = in_ready_q;
  assign shift_en_o         = shift_en_q;
  assign err_latch_o        = err_latch_q;
  assign weight_cal_state_o = wcal_q;
  assign out_valid_o        = out_valid_q;
  assign busy_o             = busy_q;
  assign iter_cnt_o         = iter_cnt_q;
  assign state_o            = state_q;

endmodule

// File: tb/tb_lms_update_ctrl.sv
// Bench for lms_update_ctrl: directed sequences plus random traffic, checked
// every cycle against a sample-timeline model (cycles since accept).
module tb_lms_update_ctrl;
  import lms_update_ctrl_pkg::*;

  localparam int FIR_LAT = 4;
  localparam int DIV_LAT = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic in_valid = 1'b0;
  logic adapt_en = 1'b0;
  logic out_ready = 1'b0;

  logic        in_ready, shift_en, err_latch, wcal, out_valid, busy;
  logic [15:0] iter_cnt;
  lms_state_e  state;
  logic        in_ready4, shift_en4, err_latch4, wcal4, out_valid4, busy4;
  logic [3:0]  iter_cnt4;
  lms_state_e  state4;

  lms_update_ctrl #(.FIR_LAT(FIR_LAT), .DIV_LAT(DIV_LAT), .ITER_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .adapt_en_i(adapt_en), .shift_en_o(shift_en), .err_latch_o(err_latch),
    .weight_cal_state_o(wcal), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .busy_o(busy), .iter_cnt_o(iter_cnt), .state_o(state)
  );

  lms_update_ctrl #(.FIR_LAT(FIR_LAT), .DIV_LAT(DIV_LAT), .ITER_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(in_ready4),
    .adapt_en_i(adapt_en), .shift_en_o(shift_en4), .err_latch_o(err_latch4),
    .weight_cal_state_o(wcal4), .out_valid_o(out_valid4), .out_ready_i(out_ready),
    .busy_o(busy4), .iter_cnt_o(iter_cnt4), .state_o(state4)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];   // expected cycle numbers of weight update pulses

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // A sample is described by its age in cycles since the accept cycle (age 0).
  bit m_active   = 0;
  int m_age      = 0;
  bit m_adapt    = 0;
  bit m_ready_en = 0;
  int m_iter     = 0;

  int cyc      = 0;
  int acc_cnt  = 0;
  int wcal_cnt = 0;
  int ov_cnt   = 0;
  int acc_t[$];

  function automatic int out_start();
    return m_adapt ? (FIR_LAT + DIV_LAT + 4) : (FIR_LAT + 3);
  endfunction

  task automatic model_reset();
    m_active   = 0;
    m_age      = 0;
    m_adapt    = 0;
    m_ready_en = 0;
    m_iter     = 0;
    exp_q.delete();
  endtask

  // Predict the effect of the coming rising edge given the driven inputs.
  task automatic model_step(input bit iv, input bit ae, input bit ordy);
    if (!m_active) begin
      if (m_ready_en && iv) begin
        m_active = 1;
        m_age    = 1;
        m_adapt  = 0;
      end
    end else begin
      if (m_age == FIR_LAT + 2) begin
        m_adapt = ae;
        if (ae) exp_q.push_back(32'(cyc + 1 + DIV_LAT));
      end
      if (m_age >= out_start() && ordy) begin
        m_active = 0;
      end else begin
        if (m_adapt && m_age == FIR_LAT + DIV_LAT + 3) m_iter++;
        m_age++;
      end
    end
    m_ready_en = 1;
  endtask

  task automatic check_all();
    int i16, i4;
    i16 = (m_iter > 65535) ? 65535 : m_iter;
    i4  = (m_iter > 15) ? 15 : m_iter;
    check_eq("in_ready",  32'(in_ready),  32'(!m_active && m_ready_en));
    check_eq("shift_en",  32'(shift_en),  32'(m_active && m_age == 1));
    check_eq("err_latch", 32'(err_latch), 32'(m_active && m_age == FIR_LAT + 2));
    check_eq("wcal",      32'(wcal),      32'(m_active && m_adapt && m_age == FIR_LAT + DIV_LAT + 3));
    check_eq("out_valid", 32'(out_valid), 32'(m_active && m_age >= out_start()));
    check_eq("busy",      32'(busy),      32'(m_active));
    check_eq("idle_state", 32'(state == ST_IDLE), 32'(!m_active));
    check_eq("iter_cnt",  32'(iter_cnt),  32'(i16));
    check_eq("iter_cnt4", 32'(iter_cnt4), 32'(i4));
    check_eq("wcal4",     32'(wcal4),     32'(wcal === 1'b1));
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge: drive inputs, predict the next edge, then check
  // at the following falling edge.
  task automatic tick(input bit iv, input bit ae, input bit ordy, input bit r);
    in_valid  = iv;
    adapt_en  = ae;
    out_ready = ordy;
    rst       = r;
    if (r) begin
      model_reset();
      #1;
      check_all();
    end else begin
      if (in_ready === 1'b1 && iv) begin
        acc_cnt++;
        acc_t.push_back(cyc);
      end
      model_step(iv, ae, ordy);
    end
    @(negedge clk);
    cyc++;
    if (wcal === 1'b1) begin
      wcal_cnt++;
      if (exp_q.size() == 0) check_eq("wcal_unexpected", 32'(cyc), 32'hFFFF_FFFF);
      else check_eq("wcal_time", 32'(cyc), exp_q.pop_front());
    end
    if (out_valid === 1'b1) ov_cnt++;
    check_all();
  endtask

  task automatic do_reset();
    tick(0, 0, 1, 1);
    tick(0, 0, 1, 1);
    tick(0, 0, 1, 0);   // first edge after release raises in_ready
    acc_cnt  = 0;
    wcal_cnt = 0;
    ov_cnt   = 0;
    acc_t.delete();
  endtask

  // ---------------- tests ----------------
  initial begin
    bit ae;
    @(negedge clk);
    model_reset();
    check_all();

    // single adapting sample
    do_reset();
    tick(1, 1, 1, 0);
    for (int i = 0; i < 14; i++) tick(0, 1, 1, 0);
    check_eq("t1_iter", 32'(iter_cnt), 32'd1);
    check_eq("t1_wcal_cnt", 32'(wcal_cnt), 32'd1);

    // single non-adapting sample
    do_reset();
    tick(1, 0, 1, 0);
    for (int i = 0; i < 10; i++) tick(0, 0, 1, 0);
    check_eq("t2_iter", 32'(iter_cnt), 32'd0);
    check_eq("t2_wcal_cnt", 32'(wcal_cnt), 32'd0);

    // output stall: out_ready low for the first five OUT cycles
    do_reset();
    tick(1, 0, 0, 0);
    for (int i = 0; i < 11; i++) tick(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick(0, 0, 1, 0);
    check_eq("t3_ov_cycles", 32'(ov_cnt), 32'd6);

    // continuous input, adapt_en wiggled only while in DIVW
    do_reset();
    for (int i = 0; i < 120; i++) begin
      ae = 1;
      if (m_active && m_age > FIR_LAT + 2 && m_age <= FIR_LAT + DIV_LAT + 3)
        ae = bit'($urandom_range(0, 1));
      tick(1, ae, 1, 0);
    end
    for (int i = 0; i < 4; i++) tick(0, 1, 1, 0);
    check_eq("t4_accepts", 32'(acc_cnt), 32'd10);
    check_eq("t4_wcal_cnt", 32'(wcal_cnt), 32'd10);
    check_eq("t4_iter", 32'(iter_cnt), 32'd10);
    for (int i = 1; i < acc_t.size(); i++)
      check_eq("t4_spacing", 32'(acc_t[i] - acc_t[i-1]), 32'd12);

    // reset while waiting on the divider
    do_reset();
    tick(1, 1, 1, 0);
    for (int i = 0; i < FIR_LAT + 3; i++) tick(0, 1, 1, 0);
    check_eq("t5_in_divw", 32'(state == ST_DIVW), 32'd1);
    do_reset();
    for (int i = 0; i < 15; i++) tick(0, 1, 1, 0);
    check_eq("t5_wcal_cnt", 32'(wcal_cnt), 32'd0);
    check_eq("t5_iter", 32'(iter_cnt), 32'd0);

    // saturation of the 4-bit counter
    do_reset();
    for (int i = 0; i < 17 * 12; i++) tick(1, 1, 1, 0);
    for (int i = 0; i < 4; i++) tick(0, 1, 1, 0);
    check_eq("t6_iter4_sat", 32'(iter_cnt4), 32'd15);
    check_eq("t6_iter16", 32'(iter_cnt), 32'd17);

    // random traffic with rare resets
    do_reset();
    for (int i = 0; i < 800; i++)
      tick($urandom_range(0, 3) != 0, bit'($urandom_range(0, 1)),
           $urandom_range(0, 2) != 0, $urandom_range(0, 299) == 0);
    for (int i = 0; i < 25; i++) tick(0, 0, 1, 0);
    check_eq("rand_pending_wcal", 32'(exp_q.size()), 32'd0);
    check_eq("rand_idle", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard time limit in case stimulus ever stalls.
  initial begin
    #2000000;
    $display("FAIL timeout got=%0d exp=%0d", cyc, 0);
    $fatal(1, "timeout");
  end

endmodule
